// File: rtl/general_purpose_input_if.sv
// ---------------------------------------------------------------------------
// general_purpose_input_if
//   Valid/ready ("Decoupled") channel used by the general-purpose input block
//   for both its command input and its event output.
//
//   Signals
//     valid  - producer has a word on bits this cycle
//     ready  - consumer accepts the word on this cycle
//     bits   - WIDTH-bit payload
//
//   Modports
//     master - producer side (drives valid/bits, observes ready)
//     slave  - consumer side (observes valid/bits, drives ready)
// ---------------------------------------------------------------------------
interface general_purpose_input_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] bits;

  modport master (
    output valid,
    output bits,
    input  ready
  );

  modport slave (
    input  valid,
    input  bits,
    output ready
  );
endinterface

// File: rtl/general_purpose_input.sv
// ---------------------------------------------------------------------------
// general_purpose_input
//   Input-side counterpart of the GPIO output block. Eight asynchronous pins
//   pass through a two-flop synchronizer and a per-bit debounce filter. Every
//   change of the filtered (stable) vector is queued as an 8-bit snapshot in a
//   small event FIFO that the CPU side drains over a valid/ready channel. A
//   command channel accepts flush (bit0) and snapshot (bit1) requests.
//
//   Build option
//     GPIN_DEBOUNCE_EN - when defined, each bit must differ from its stable
//                        value for DEBOUNCE_CYCLES consecutive synchronized
//                        cycles before it is accepted. When undefined the
//                        counters are not built and the stable vector simply
//                        follows the synchronizer output every cycle.
//
//   Parameters
//     DEBOUNCE_CYCLES - filter length in cycles (>= 1)
//     DEPTH           - event FIFO entries (power of 2, >= 2)
//
//   Ports
//     i_clk      - clock
//     i_rst      - synchronous, active-high reset
//     if_din     - command channel (slave); ready is always high
//                  bit0 = flush, bit1 = snapshot, bits 7:2 ignored
//     if_dout    - event channel (master); bits = FIFO head snapshot
//     i_gpin     - asynchronous external pins
//     o_level    - current debounced pin vector
//     o_overflow - sticky: an event was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module general_purpose_input #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEPTH           = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  general_purpose_input_if.slave         if_din,
  general_purpose_input_if.master        if_dout,
  input  logic [7:0]                     i_gpin,
  output logic [7:0]                     o_level,
  output logic                           o_overflow
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // -------------------------------------------------------------------------
  // Synchronizer and stable vector
  // -------------------------------------------------------------------------
  logic [7:0] sync1_r;
  logic [7:0] sync2_r;
  logic [7:0] stable_r;
  logic [7:0] stable_next_s;

  // Two-flop synchronizer; only sync2_r is used downstream.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_r <= 8'h00;
      sync2_r <= 8'h00;
    end else begin
      sync1_r <= i_gpin;
      sync2_r <= sync1_r;
    end
  end

`ifdef GPIN_DEBOUNCE_EN
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] cnt_r      [8];
  logic [CNT_W-1:0] cnt_next_s [8];

  // Per-bit filter: count consecutive cycles that sync2 disagrees with the
  // stable value; the count reaching DEBOUNCE_CYCLES-1 while still disagreeing
  // means this is the DEBOUNCE_CYCLES-th such cycle, so the bit is accepted.
  always_comb begin
    stable_next_s = stable_r;
    for (int i = 0; i < 8; i++) begin
      cnt_next_s[i] = CNT_ZERO;
      if (sync2_r[i] == stable_r[i]) begin
        cnt_next_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_LAST) begin
        stable_next_s[i] = sync2_r[i];
        cnt_next_s[i]    = CNT_ZERO;
      end else begin
        cnt_next_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Debounce counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
    end
  end
`else
  // Filter disabled: the stable vector follows the synchronizer directly.
  always_comb begin
    stable_next_s = sync2_r;
  end
`endif

  // Stable (debounced) vector register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stable_r <= 8'h00;
    end else begin
      stable_r <= stable_next_s;
    end
  end

  // -------------------------------------------------------------------------
  // Command decode
  // -------------------------------------------------------------------------
  logic flush_s;
  logic snap_s;
  logic change_s;
  logic push_s;
  logic unused_cmd_bits_s;

  assign if_din.ready      = 1'b1;
  assign flush_s           = if_din.valid & if_din.bits[0];
  assign snap_s            = if_din.valid & if_din.bits[1];
  assign unused_cmd_bits_s = ^if_din.bits[7:2];

  // A change event and a snapshot on the same edge both want to push the same
  // value, so they collapse into a single push.
  assign change_s = (stable_next_s != stable_r);
  assign push_s   = change_s | snap_s;

  // -------------------------------------------------------------------------
  // Event FIFO: pointers carry one extra wrap bit to tell full from empty.
  // -------------------------------------------------------------------------
  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [AW:0] wr_ptr_next_s;
  logic [AW:0] rd_ptr_next_s;
  logic        valid_r;
  logic        overflow_r;
  logic        overflow_next_s;
  logic        wr_en_s;
  logic        empty_s;
  logic        full_s;
  logic        pop_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s   = (~empty_s) & if_dout.ready;

  // Next-state for pointers and overflow. Flush wins over any pop or change
  // event on the same edge; a snapshot alongside flush becomes the only entry.
  // Fullness is judged before the pop, so a pop makes room for a push.
  always_comb begin
    wr_ptr_next_s   = wr_ptr_r;
    rd_ptr_next_s   = rd_ptr_r;
    overflow_next_s = overflow_r;
    wr_en_s         = 1'b0;
    if (flush_s) begin
      rd_ptr_next_s   = wr_ptr_r;
      overflow_next_s = 1'b0;
      if (snap_s) begin
        wr_en_s       = 1'b1;
        wr_ptr_next_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_en_s       = 1'b0;
        wr_ptr_next_s = wr_ptr_r;
      end
    end else begin
      if (pop_s) begin
        rd_ptr_next_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      if (push_s) begin
        if (!full_s || pop_s) begin
          wr_en_s       = 1'b1;
          wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
          overflow_next_s = 1'b1;
        end
      end else begin
        wr_en_s       = 1'b0;
        wr_ptr_next_s = wr_ptr_r;
      end
    end
  end

  // FIFO pointers, registered valid and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_r   <= {(AW + 1){1'b0}};
      rd_ptr_r   <= {(AW + 1){1'b0}};
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_next_s;
      rd_ptr_r   <= rd_ptr_next_s;
      valid_r    <= (wr_ptr_next_s != rd_ptr_next_s);
      overflow_r <= overflow_next_s;
    end
  end

  // FIFO storage; the written value is always the post-edge stable vector.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= stable_next_s;
    end else begin
      mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
    end
  end

  assign if_dout.valid = valid_r;
  assign if_dout.bits  = mem_r[rd_ptr_r[AW-1:0]];
  assign o_level       = stable_r;
  assign o_overflow    = overflow_r;

endmodule

// File: tb/tb_general_purpose_input.sv
// ---------------------------------------------------------------------------
// tb_general_purpose_input
//   Directed scenarios followed by randomized pins/commands/ready, all checked
//   every cycle against a reference model. The model treats the synchronizer
//   as a two-sample delay, decides debounce acceptance from a sliding window of
//   the last DEBOUNCE_CYCLES synchronized samples, and keeps the event FIFO as
//   a queue.
// ---------------------------------------------------------------------------
module tb_general_purpose_input;

  localparam int DEB   = 16;
  localparam int DEPTH = 4;
`ifdef GPIN_DEBOUNCE_EN
  localparam int LAT = DEB + 2;
`else
  localparam int LAT = 3;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_gpin = 8'h00;
  logic [7:0] o_level;
  logic       o_overflow;

  int checks = 0;
  int errors = 0;

  general_purpose_input_if #(.WIDTH(8)) din_if ();
  general_purpose_input_if #(.WIDTH(8)) dout_if ();

  general_purpose_input #(
    .DEBOUNCE_CYCLES (DEB),
    .DEPTH           (DEPTH)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .if_din     (din_if),
    .if_dout    (dout_if),
    .i_gpin     (i_gpin),
    .o_level    (o_level),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic [7:0] m_sync1 = 8'h00;
  logic [7:0] m_sync2 = 8'h00;
  logic [7:0] m_st    = 8'h00;
  logic       m_ovf   = 1'b0;
  logic [7:0] m_win[$];
  logic [7:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stable vector after the coming edge, from the window of synchronized samples.
  function automatic logic [7:0] model_next();
    logic [7:0] sn;
`ifdef GPIN_DEBOUNCE_EN
    logic [7:0] w[$];
    bit all_diff;
    w = m_win;
    w.push_back(m_sync2);
    if (w.size() > DEB) void'(w.pop_front());
    for (int i = 0; i < 8; i++) begin
      all_diff = 1'b1;
      foreach (w[j]) if (w[j][i] == m_st[i]) all_diff = 1'b0;
      sn[i] = all_diff ? ~m_st[i] : m_st[i];
    end
`else
    sn = m_sync2;
`endif
    return sn;
  endfunction

  task automatic model_edge();
    logic [7:0] sn;
    bit flush, snap, full, pop;
    if (i_rst) begin
      m_sync1 = 8'h00;
      m_sync2 = 8'h00;
      m_st    = 8'h00;
      m_ovf   = 1'b0;
      m_q.delete();
      m_win.delete();
      repeat (DEB) m_win.push_back(8'h00);
    end else begin
      sn = model_next();
      m_win.push_back(m_sync2);
      if (m_win.size() > DEB) void'(m_win.pop_front());
      flush = din_if.valid && din_if.bits[0];
      snap  = din_if.valid && din_if.bits[1];
      if (flush) begin
        m_q.delete();
        m_ovf = 1'b0;
        if (snap) m_q.push_back(sn);
      end else begin
        full = (m_q.size() == DEPTH);
        pop  = (m_q.size() != 0) && dout_if.ready;
        if (pop) void'(m_q.pop_front());
        if ((sn != m_st) || snap) begin
          if (!full || pop) m_q.push_back(sn);
          else m_ovf = 1'b1;
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = i_gpin;
      m_st    = sn;
    end
  endtask

  task automatic check_outputs();
    chk("level", {24'h0, o_level}, {24'h0, m_st});
    chk("overflow", {31'h0, o_overflow}, {31'h0, m_ovf});
    chk("valid", {31'h0, dout_if.valid}, {31'h0, (m_q.size() != 0)});
    if (m_q.size() != 0) chk("head", {24'h0, dout_if.bits}, {24'h0, m_q[0]});
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      model_edge();
      @(posedge i_clk);
      @(negedge i_clk);
      check_outputs();
    end
  endtask

  task automatic command(input logic [7:0] cmd);
    din_if.valid = 1'b1;
    din_if.bits  = cmd;
    cycle(1);
    din_if.valid = 1'b0;
    din_if.bits  = 8'h00;
  endtask

  initial begin
    int lat;
    bit seen;
    bit hit;
    logic [7:0] base;
    logic [7:0] exp_seq[4];
    int hold;
    int ready_pct;

    din_if.valid  = 1'b0;
    din_if.bits   = 8'h00;
    dout_if.ready = 1'b0;
    @(negedge i_clk);

    // Reset, then idle with pins low.
    i_rst = 1'b1;
    cycle(5);
    i_rst = 1'b0;
    cycle(50);
    chk("reset_level", {24'h0, o_level}, 32'h0);
    chk("reset_valid", {31'h0, dout_if.valid}, 32'h0);
    chk("reset_ovf", {31'h0, o_overflow}, 32'h0);

    // Pins to A5: measure edges until o_level follows.
    i_gpin = 8'hA5;
    dout_if.ready = 1'b1;
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      cycle(1);
      lat = k + 1;
      if (o_level === 8'hA5) seen = 1'b1;
    end
    chk("latency", lat, LAT);
    cycle(3);
    chk("a5_drained", {31'h0, dout_if.valid}, 32'h0);

    // Back to 00, then a 10-cycle pulse on bit0 with nobody draining.
    i_gpin = 8'h00;
    cycle(LAT + 5);
    dout_if.ready = 1'b0;
    i_gpin = 8'h01;
    cycle(10);
    i_gpin = 8'h00;
    cycle(LAT + 5);
    chk("glitch_level", {24'h0, o_level}, 32'h0);
`ifdef GPIN_DEBOUNCE_EN
    chk("glitch_valid", {31'h0, dout_if.valid}, 32'h0);
`else
    chk("glitch_head", {24'h0, dout_if.bits}, 32'h01);
`endif

    // Overflow: five changes into a four-entry FIFO with ready low.
    command(8'h01);
    foreach (exp_seq[i]) exp_seq[i] = 8'h00;
    for (int v = 0; v < 5; v++) begin
      i_gpin = 8'((1 << (v + 1)) - 1);
      cycle(LAT + 3);
    end
    chk("ovf_set", {31'h0, o_overflow}, 32'h1);
    exp_seq[0] = 8'h01; exp_seq[1] = 8'h03; exp_seq[2] = 8'h07; exp_seq[3] = 8'h0F;
    dout_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", {24'h0, dout_if.bits}, {24'h0, exp_seq[i]});
      cycle(1);
    end
    chk("drain_empty", {31'h0, dout_if.valid}, 32'h0);

    // Full FIFO with a change event landing on the same edge as a pop.
    dout_if.ready = 1'b0;
    command(8'h01);
    i_gpin = 8'h1E; cycle(LAT + 3);
    i_gpin = 8'h1C; cycle(LAT + 3);
    i_gpin = 8'h18; cycle(LAT + 3);
    i_gpin = 8'h10; cycle(LAT + 3);
    i_gpin = 8'h00;
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      dout_if.ready = (model_next() != m_st);
      hit = dout_if.ready;
      cycle(1);
    end
    dout_if.ready = 1'b0;
    chk("coinc_ovf", {31'h0, o_overflow}, 32'h0);
    chk("coinc_level", {24'h0, o_level}, 32'h0);
    exp_seq[0] = 8'h1C; exp_seq[1] = 8'h18; exp_seq[2] = 8'h10; exp_seq[3] = 8'h00;
    dout_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("coinc_order", {24'h0, dout_if.bits}, {24'h0, exp_seq[i]});
      cycle(1);
    end
    chk("coinc_empty", {31'h0, dout_if.valid}, 32'h0);

    // Flush+snapshot with two queued entries and level 5A.
    dout_if.ready = 1'b0;
    i_gpin = 8'h5B; cycle(LAT + 3);
    i_gpin = 8'h5A; cycle(LAT + 3);
    command(8'h03);
    chk("fs_ovf", {31'h0, o_overflow}, 32'h0);
    chk("fs_valid", {31'h0, dout_if.valid}, 32'h1);
    chk("fs_head", {24'h0, dout_if.bits}, 32'h5A);
    dout_if.ready = 1'b1;
    cycle(1);
    chk("fs_empty", {31'h0, dout_if.valid}, 32'h0);

    // Randomized traffic with occasional glitches, commands and resets.
    base = 8'h00;
    hold = 0;
    ready_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if ((c % 200) == 0) ready_pct = $urandom_range(0, 100);
      if (hold == 0) begin
        base = 8'($urandom);
        hold = $urandom_range(1, 3 * LAT);
      end else begin
        hold--;
      end
      i_gpin = base;
      if ($urandom_range(0, 7) == 0) i_gpin = base ^ 8'(1 << $urandom_range(0, 7));
      dout_if.ready = ($urandom_range(1, 100) <= ready_pct);
      din_if.valid  = ($urandom_range(0, 24) == 0);
      din_if.bits   = 8'($urandom);
      i_rst         = ($urandom_range(0, 499) == 0);
      cycle(1);
    end
    i_rst = 1'b0;
    din_if.valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
